// File: rtl/alu_ops_pkg.sv
// ALU operation codes shared by the control decoder and the HI/LO multiply unit,
// plus the multiply-unit FSM state type and opcode classification helpers.
package alu_ops_pkg;

  localparam logic [4:0] OpMul   = 5'b10010;
  localparam logic [4:0] OpMultu = 5'b10011;
  localparam logic [4:0] OpMadd  = 5'b10100;
  localparam logic [4:0] OpMsub  = 5'b10101;
  localparam logic [4:0] OpMult  = 5'b10110;
  localparam logic [4:0] OpMflo  = 5'b11000;
  localparam logic [4:0] OpMthi  = 5'b11001;
  localparam logic [4:0] OpMtlo  = 5'b11010;
  localparam logic [4:0] OpMfhi  = 5'b11011;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFinish
  } mul_state_e;

  function automatic logic is_mult_op(input logic [4:0] op);
    return op inside {OpMul, OpMultu, OpMadd, OpMsub, OpMult};
  endfunction

  function automatic logic is_single_op(input logic [4:0] op);
    return op inside {OpMflo, OpMthi, OpMtlo, OpMfhi};
  endfunction

  function automatic logic is_signed_op(input logic [4:0] op);
    return is_mult_op(op) && (op != OpMultu);
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// Unsigned WIDTH x WIDTH radix-2 shift-add multiplier, one iteration per step.
// The multiplier occupies the low half of the product register and shifts out as sums shift in.
module shift_add_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               count_done
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     sum;

  assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      mcand_q <= multiplicand;
      prod_q  <= {{WIDTH{1'b0}}, multiplier};
      cnt_q   <= '0;
    end else if (step) begin
      prod_q  <= {sum, prod_q[WIDTH-1:1]};
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  assign product = prod_q;
  // High while the final iteration is being performed, so the FSM leaves RUN on that edge.
  assign count_done = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/hilo_multiplier.sv
// HI/LO execution unit: MTHI/MTLO/MFHI/MFLO in one cycle, MUL/MULT/MULTU/MADD/MSUB
// through a 32-iteration shift-add core with sign-magnitude correction and accumulation.
module hilo_multiplier
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [4:0]       ALUInstruction,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  mul_state_e         state_q, state_d;
  logic [4:0]         op_q;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic               done_q, done_d;
  logic               accept, mul_start, core_load, core_step, count_done;
  logic [WIDTH-1:0]   mag_a, mag_b, result_commit;
  logic [2*WIDTH-1:0] product, product_s, hilo_commit;

  // FINISH also accepts a new request, so the next op overlaps the commit edge.
  assign accept = Start && (state_q == StIdle || state_q == StFinish) &&
                  (is_mult_op(ALUInstruction) || is_single_op(ALUInstruction));
  assign mul_start = accept && is_mult_op(ALUInstruction);

  always_comb begin
    mag_a = A;
    mag_b = B;
    neg_d = 1'b0;
    if (is_signed_op(ALUInstruction)) begin
      if (A[WIDTH-1]) mag_a = -A;
      if (B[WIDTH-1]) mag_b = -B;
      neg_d = A[WIDTH-1] ^ B[WIDTH-1];
    end
  end

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .load        (core_load),
    .step        (core_step),
    .multiplicand(mag_a),
    .multiplier  (mag_b),
    .product     (product),
    .count_done  (count_done)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (mul_start) state_d = StRun;
      StRun:    if (count_done) state_d = StFinish;
      StFinish: state_d = mul_start ? StRun : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    Busy      = (state_q != StIdle);
    core_load = mul_start;
    core_step = (state_q == StRun);
    done_d    = (state_q == StFinish) || (accept && is_single_op(ALUInstruction));
  end

  always_comb begin
    product_s     = neg_q ? -product : product;
    hilo_commit   = {hi_q, lo_q};
    result_commit = result_q;
    if (state_q == StFinish) begin
      case (op_q)
        OpMult, OpMultu: hilo_commit = product_s;
        OpMadd:          hilo_commit = {hi_q, lo_q} + product_s;
        OpMsub:          hilo_commit = {hi_q, lo_q} - product_s;
        OpMul:           result_commit = product_s[WIDTH-1:0];
        default:         ;
      endcase
    end
    hi_d     = hilo_commit[2*WIDTH-1:WIDTH];
    lo_d     = hilo_commit[WIDTH-1:0];
    result_d = result_commit;
    // Moves read the just-committed HI/LO when issued on the commit edge.
    if (accept) begin
      case (ALUInstruction)
        OpMthi:  hi_d = A;
        OpMtlo:  lo_d = A;
        OpMfhi:  result_d = hilo_commit[2*WIDTH-1:WIDTH];
        OpMflo:  result_d = hilo_commit[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      if (mul_start) begin
        op_q  <= ALUInstruction;
        neg_q <= neg_d;
      end
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign Done   = done_q;
  assign Result = result_q;
  assign HI     = hi_q;
  assign LO     = lo_q;

endmodule

// File: tb/tb_hilo_multiplier.sv
// Self-checking bench for hilo_multiplier: a 64-bit arithmetic reference model compared
// every cycle, plus directed vectors with hand-computed HI/LO/Result values.
module tb_hilo_multiplier;
  localparam logic [4:0] CMul   = 5'b10010;
  localparam logic [4:0] CMultu = 5'b10011;
  localparam logic [4:0] CMadd  = 5'b10100;
  localparam logic [4:0] CMsub  = 5'b10101;
  localparam logic [4:0] CMult  = 5'b10110;
  localparam logic [4:0] CMflo  = 5'b11000;
  localparam logic [4:0] CMthi  = 5'b11001;
  localparam logic [4:0] CMtlo  = 5'b11010;
  localparam logic [4:0] CMfhi  = 5'b11011;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [4:0]  ALUInstruction = 5'b0;
  logic [31:0] A = '0, B = '0;
  logic        Busy, Done;
  logic [31:0] Result, HI, LO;

  int errors = 0;
  int checks = 0;

  hilo_multiplier #(
    .WIDTH(32)
  ) dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Start         (Start),
    .ALUInstruction(ALUInstruction),
    .A             (A),
    .B             (B),
    .Busy          (Busy),
    .Done          (Done),
    .Result        (Result),
    .HI            (HI),
    .LO            (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining until a pending multiply commits.
  logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
  logic        m_done = 1'b0;
  int          m_rem = 0;
  logic [4:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;

  function automatic logic [63:0] ref_product(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [63:0] sa, sb;
    if (op == CMultu) return {32'b0, a} * {32'b0, b};
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return 64'(sa * sb);
  endfunction

  always @(posedge Clk or negedge Rst_n) begin
    logic [63:0] p, acc;
    if (!Rst_n) begin
      m_hi = '0; m_lo = '0; m_res = '0; m_done = 1'b0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          p   = ref_product(m_op, m_a, m_b);
          acc = {m_hi, m_lo};
          case (m_op)
            CMult, CMultu: acc = p;
            CMadd:         acc = acc + p;
            CMsub:         acc = acc - p;
            CMul:          m_res = p[31:0];
            default:       ;
          endcase
          {m_hi, m_lo} = acc;
          m_done = 1'b1;
        end
      end
      if (Start && m_rem == 0) begin
        case (ALUInstruction)
          CMthi: begin m_hi = A; m_done = 1'b1; end
          CMtlo: begin m_lo = A; m_done = 1'b1; end
          CMfhi: begin m_res = m_hi; m_done = 1'b1; end
          CMflo: begin m_res = m_lo; m_done = 1'b1; end
          CMul, CMultu, CMadd, CMsub, CMult: begin
            m_op = ALUInstruction; m_a = A; m_b = B; m_rem = 33;
          end
          default: ;
        endcase
      end
    end
  end

  always @(posedge Clk) begin
    #1;
    check("cyc_busy", 32'(Busy), 32'(m_rem != 0));
    check("cyc_done", 32'(Done), 32'(m_done));
    check("cyc_hi", HI, m_hi);
    check("cyc_lo", LO, m_lo);
    check("cyc_result", Result, m_res);
  end

  // Returns at the negedge after the accepting edge, with inputs scrambled.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; ALUInstruction = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; ALUInstruction = 5'b00000; A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin
        seen = 1'b1;
        break;
      end
      if (Busy) busy_cycles++;
      @(negedge Clk);
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    check("rst_result", Result, 32'h0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Rst_n = 1'b1;

    issue(CMultu, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    check("multu_busy_len", n, 32'd33);
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);
    @(negedge Clk);
    check("multu_done_once", 32'(Done), 32'd0);

    issue(CMult, 32'hFFFFFFFD, 32'd5);
    wait_done(n);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);

    issue(CMthi, 32'h12345678, 32'h0);
    wait_done(n);
    issue(CMtlo, 32'h9ABCDEF0, 32'h0);
    wait_done(n);
    check("mt_hi", HI, 32'h12345678);
    check("mt_lo", LO, 32'h9ABCDEF0);

    issue(CMadd, 32'd2, 32'd3);
    wait_done(n);
    check("madd_hi", HI, 32'h12345678);
    check("madd_lo", LO, 32'h9ABCDEF6);

    issue(CMsub, 32'h80000000, 32'd2);
    wait_done(n);
    check("msub_hi", HI, 32'h12345679);
    check("msub_lo", LO, 32'h9ABCDEF6);

    issue(CMfhi, 32'h0, 32'h0);
    wait_done(n);
    check("mfhi_latency", n, 32'd0);
    check("mfhi_result", Result, 32'h12345679);

    issue(CMul, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n);
    check("mul_result", Result, 32'h80000000);
    check("mul_hi_kept", HI, 32'h12345679);
    check("mul_lo_kept", LO, 32'h9ABCDEF6);

    issue(5'b11111, 32'h55555555, 32'h1);
    repeat (3) begin
      check("badop_no_done", 32'(Done), 32'd0);
      @(negedge Clk);
    end
    check("badop_hi", HI, 32'h12345679);
    check("badop_lo", LO, 32'h9ABCDEF6);
    check("badop_busy", 32'(Busy), 32'd0);

    issue(CMult, 32'h00010000, 32'h00010000);
    repeat (8) @(negedge Clk);
    Start = 1'b1; ALUInstruction = CMtlo; A = 32'hDEADBEEF;
    @(negedge Clk);
    Start = 1'b0; ALUInstruction = 5'b0;
    wait_done(n);
    check("busy_drop_hi", HI, 32'h00000001);
    check("busy_drop_lo", LO, 32'h00000000);

    // MFLO on the commit edge must see the freshly committed LO.
    issue(CMult, 32'd7, 32'd9);
    repeat (32) @(negedge Clk);
    Start = 1'b1; ALUInstruction = CMflo;
    @(negedge Clk);
    Start = 1'b0; ALUInstruction = 5'b0;
    check("fwd_done", 32'(Done), 32'd1);
    check("fwd_result", Result, 32'd63);
    check("fwd_busy", 32'(Busy), 32'd0);
    @(negedge Clk);

    issue(CMadd, 32'd5, 32'd5);
    repeat (19) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("abort_hi", HI, 32'h0);
    check("abort_lo", LO, 32'h0);
    check("abort_result", Result, 32'h0);
    check("abort_busy", 32'(Busy), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;

    issue(CMult, 32'd7, 32'd6);
    wait_done(n);
    check("post_rst_lo", LO, 32'd42);
    check("post_rst_hi", HI, 32'd0);

    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
